// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and helpers for the A2D conversion scheduler.
// Holds the slot enum, ADC128S channel numbers, scheduler state enum and
// the SPI command builder. Imported by a2d_sched and its sub-module.
package a2d_pkg;

   // Round-robin slot order of the four sampled quantities.
   typedef enum logic [1:0] {
      LFT   = 2'd0,
      RGHT  = 2'd1,
      STEER = 2'd2,
      BATT  = 2'd3
   } slot_e;

   // ADC128S input channel wired to each quantity.
   localparam logic [2:0] CHNL_LFT   = 3'd0;
   localparam logic [2:0] CHNL_RGHT  = 3'd4;
   localparam logic [2:0] CHNL_STEER = 3'd5;
   localparam logic [2:0] CHNL_BATT  = 3'd6;

   // Scheduler states: address transfer, one SS-high gap cycle, data
   // transfer, then a single result/strobe cycle.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_XFER1 = 3'd1,
      ST_GAP   = 3'd2,
      ST_XFER2 = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic [2:0] slot_chnl(slot_e s);
      logic [2:0] c;
      case (s)
         LFT:     c = CHNL_LFT;
         RGHT:    c = CHNL_RGHT;
         STEER:   c = CHNL_STEER;
         BATT:    c = CHNL_BATT;
         default: c = CHNL_LFT;
      endcase
      return c;
   endfunction

   // ADC128S control word: channel address sits in bits [13:11].
   function automatic logic [15:0] build_cmd(logic [2:0] chnl);
      return {2'b00, chnl, 11'h000};
   endfunction

   // Slot 3 wraps back to slot 0.
   function automatic slot_e next_slot(slot_e s);
      return slot_e'(s + 2'd1);
   endfunction

endpackage

// File: rtl/a2d_sched_if.sv
// a2d_sched_if: bundles the trigger, SPI master handshake and result
// outputs of the A2D scheduler. master = scheduler side (drives snd/cmd and
// results), slave = SPI master / consumer side (drives nxt, done, resp).
interface a2d_sched_if;

   logic        nxt;        // start-next-conversion strobe
   logic        snd;        // one-cycle SPI start pulse
   logic [15:0] cmd;        // SPI command word
   logic        done;       // SPI transaction complete pulse
   logic [15:0] resp;       // SPI receive word, valid with done
   logic [11:0] lft_ld;     // left load cell result
   logic [11:0] rght_ld;    // right load cell result
   logic [11:0] steer_pot;  // steering pot result
   logic [11:0] batt;       // battery result
   logic [3:0]  upd;        // one-hot update strobe {batt,steer,rght,lft}
   logic        busy;       // conversion in progress
   logic        err;        // transaction timeout pulse

   modport master (
      input  nxt, done, resp,
      output snd, cmd, lft_ld, rght_ld, steer_pot, batt, upd, busy, err
   );

   modport slave (
      output nxt, done, resp,
      input  snd, cmd, lft_ld, rght_ld, steer_pot, batt, upd, busy, err
   );

endinterface

// File: rtl/xfer_tmo.sv
// xfer_tmo: per-transaction watchdog for the SPI handshake.
// Ports: clk/rst; load_i restarts the count (asserted together with the
// registered snd); exp_o is high while the count sits at TMO_CYC-1.
module xfer_tmo
#(
   parameter int TMO_CYC = 4096
)
(
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic exp_o
);

   localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

   logic [CW-1:0] cnt_q;

   // load_i comes from the same next-state term that sets snd, so the count
   // reads 0 in the cycle snd is visible and reaches LAST TMO_CYC-1 cycles
   // later. It saturates so exp_o stays stable until the next load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= '0;
      end else if (cnt_q != LAST) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign exp_o = (cnt_q == LAST);

endmodule

// File: rtl/a2d_sched.sv
// a2d_sched: shares one SPI master between lft/rght/steer/batt conversions,
// one two-transaction ADC128S read per nxt trigger, round-robin.
// Ports: clk, rst (async, active high); a2d interface (master modport):
// nxt in, snd/cmd out, done/resp in, four 12-bit results, upd, busy, err out.
module a2d_sched
   import a2d_pkg::*;
#(
   parameter int TMO_CYC = 4096
)
(
   input  logic             clk,
   input  logic             rst,
   a2d_sched_if.master      a2d
);

   state_e      state_q, state_d;
   slot_e       slot_q, slot_d;
   logic        pend_q, pend_d;
   logic        snd_q, snd_d;
   logic [15:0] cmd_q, cmd_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [3:0]  upd_q, upd_d;
   logic [11:0] lft_q, rght_q, steer_q, batt_q;

   logic        tmo_exp;
   logic [3:0]  resp_unused;

   // Upper nibble of the ADC128S word carries no data.
   assign resp_unused = a2d.resp[15:12];

   xfer_tmo #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .load_i (snd_d),
      .exp_o  (tmo_exp)
   );

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      pend_d  = pend_q;
      cmd_d   = cmd_q;
      busy_d  = busy_q;
      snd_d   = 1'b0;
      err_d   = 1'b0;
      upd_d   = 4'b0000;

      // Any trigger outside IDLE (including the DONE cycle) is remembered
      // once; extra triggers collapse into the same flag.
      if (a2d.nxt && (state_q != ST_IDLE)) begin
         pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (a2d.nxt || pend_q) begin
               state_d = ST_XFER1;
               snd_d   = 1'b1;
               busy_d  = 1'b1;
               pend_d  = 1'b0;
               cmd_d   = build_cmd(slot_chnl(slot_q));
            end
         end

         // Address phase: the returned word belongs to the previous
         // conversion and is dropped.
         ST_XFER1: begin
            if (a2d.done) begin
               state_d = ST_GAP;
            end else if (tmo_exp) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end

         ST_GAP: begin
            state_d = ST_XFER2;
            snd_d   = 1'b1;
         end

         // Data phase: result registers load straight from resp on the
         // done edge, so the new value and upd appear together in DONE.
         ST_XFER2: begin
            if (a2d.done) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               upd_d   = 4'b0001 << slot_q;
               slot_d  = next_slot(slot_q);
            end else if (tmo_exp) begin
               // Slot is not advanced so the same channel is retried.
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         slot_q  <= LFT;
         pend_q  <= 1'b0;
         snd_q   <= 1'b0;
         cmd_q   <= 16'h0000;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         upd_q   <= 4'b0000;
         lft_q   <= 12'h000;
         rght_q  <= 12'h000;
         steer_q <= 12'h000;
         batt_q  <= 12'h000;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         pend_q  <= pend_d;
         snd_q   <= snd_d;
         cmd_q   <= cmd_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         upd_q   <= upd_d;
         if (upd_d[0]) lft_q   <= a2d.resp[11:0];
         if (upd_d[1]) rght_q  <= a2d.resp[11:0];
         if (upd_d[2]) steer_q <= a2d.resp[11:0];
         if (upd_d[3]) batt_q  <= a2d.resp[11:0];
      end
   end

   assign a2d.snd       = snd_q;
   assign a2d.cmd       = cmd_q;
   assign a2d.busy      = busy_q;
   assign a2d.err       = err_q;
   assign a2d.upd       = upd_q;
   assign a2d.lft_ld    = lft_q;
   assign a2d.rght_ld   = rght_q;
   assign a2d.steer_pot = steer_q;
   assign a2d.batt      = batt_q;

endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: directed scenarios plus random triggering of a2d_sched
// against a timestamp-based reference model and an ADC128S responder.
// Model and all comparisons run in one process, sampled on the falling edge.
module tb_a2d_sched;

   localparam int TMO = 16;
   localparam int BIG = 32'h3fff_ffff;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   a2d_sched_if bus();

   a2d_sched #(.TMO_CYC(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .a2d (bus)
   );

   // ---------------- ADC128S responder ----------------
   logic [11:0] adc_val [8];
   bit          adc_mute;
   bit          inj_req;
   bit          adc_ph;

   initial begin
      int         lat;
      logic [2:0] ch;
      bus.done = 1'b0;
      bus.resp = 16'h0000;
      adc_ph   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            adc_ph = 1'b0;
         end else if (inj_req) begin
            @(posedge clk); #1;
            bus.done = 1'b1;
            bus.resp = 16'($urandom);
            @(posedge clk); #1;
            bus.done = 1'b0;
         end else if (bus.snd && !adc_mute) begin
            lat = $urandom_range(1, 4);
            ch  = bus.cmd[13:11];
            repeat (lat) @(posedge clk);
            #1;
            bus.done = 1'b1;
            // First transaction returns stale data; second carries the
            // addressed channel, with a junk upper nibble.
            bus.resp = adc_ph ? {4'($urandom), adc_val[ch]} : 16'($urandom);
            adc_ph   = ~adc_ph;
            @(posedge clk); #1;
            bus.done = 1'b0;
            bus.resp = 16'($urandom);
         end
      end
   end

   // ---------------- reference model ----------------
   int          n_chk, n_fail, cyc;
   int          chans [4] = '{0, 4, 5, 6};
   string       res_nm [4] = '{"lft_ld", "rght_ld", "steer_pot", "batt"};

   bit          m_act, m_pend;
   int          m_slot, m_ph;
   int          snd_at, tmo_at, ready_at, busy_from, busy_until;
   int          upd_at, err_at, cmd_at, upd_slot;
   logic [11:0] upd_val;
   logic [11:0] m_res [4];
   logic [15:0] m_cmd, cmd_nxt;

   int          obs_snd_c[$], obs_done_c[$], obs_upd_c[$], obs_err_c[$];
   logic [15:0] obs_cmd[$];
   logic [3:0]  obs_upd[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] mk_cmd(int s);
      logic [2:0] ch;
      ch = 3'(chans[s]);
      return {2'b00, ch, 11'h000};
   endfunction

   function automatic logic [11:0] dut_res(int i);
      case (i)
         0:       return bus.lft_ld;
         1:       return bus.rght_ld;
         2:       return bus.steer_pot;
         default: return bus.batt;
      endcase
   endfunction

   function automatic bit m_idle();
      return !m_act && !m_pend && (cyc >= ready_at) && (cyc > upd_at) && (cyc > err_at);
   endfunction

   task automatic model_check();
      logic [3:0] e_upd;
      if (rst) begin
         m_act = 0; m_pend = 0; m_slot = 0; m_ph = 0;
         snd_at = -1; tmo_at = -1; upd_at = -1; err_at = -1; cmd_at = -1;
         busy_from = 0; busy_until = 0; ready_at = cyc + 1;
         m_cmd = 16'h0000;
         for (int i = 0; i < 4; i++) m_res[i] = 12'h000;
      end
      if (cyc == cmd_at) m_cmd = cmd_nxt;
      if (cyc == upd_at) m_res[upd_slot] = upd_val;
      e_upd = (cyc == upd_at) ? 4'(1 << upd_slot) : 4'b0000;

      chk("snd",  bus.snd,  cyc == snd_at);
      chk("busy", bus.busy, (cyc >= busy_from) && (cyc < busy_until));
      chk("upd",  bus.upd,  e_upd);
      chk("err",  bus.err,  cyc == err_at);
      chk("cmd",  bus.cmd,  m_cmd);
      for (int i = 0; i < 4; i++) chk(res_nm[i], dut_res(i), m_res[i]);

      if (bus.snd) begin obs_snd_c.push_back(cyc); obs_cmd.push_back(bus.cmd); end
      if (bus.done) obs_done_c.push_back(cyc);
      if (bus.upd != 4'b0000) begin obs_upd_c.push_back(cyc); obs_upd.push_back(bus.upd); end
      if (bus.err) obs_err_c.push_back(cyc);

      if (!rst) begin
         if (!m_act && cyc >= ready_at) begin
            if (bus.nxt || m_pend) begin
               m_act = 1; m_pend = 0; m_ph = 1;
               snd_at = cyc + 1; tmo_at = cyc + TMO;
               busy_from = cyc + 1; busy_until = BIG;
               cmd_nxt = mk_cmd(m_slot); cmd_at = cyc + 1;
            end
         end else begin
            if (bus.nxt) m_pend = 1;
            if (m_act && cyc >= snd_at) begin
               if (bus.done) begin
                  if (m_ph == 1) begin
                     m_ph = 2; snd_at = cyc + 2; tmo_at = cyc + 2 + TMO - 1;
                  end else begin
                     upd_at = cyc + 1; upd_slot = m_slot; upd_val = bus.resp[11:0];
                     busy_until = cyc + 1; m_slot = (m_slot + 1) % 4;
                     m_act = 0; ready_at = cyc + 2;
                  end
               end else if (cyc == tmo_at) begin
                  err_at = cyc + 1; busy_until = cyc + 1;
                  m_act = 0; ready_at = cyc + 1;
               end
            end
         end
      end
      cyc++;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_nxt();
      bus.nxt = 1'b1;
      step();
      bus.nxt = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!m_idle() && n < 200) begin step(); n++; end
      chk("wait_idle_bound", n < 200, 1);
   endtask

   task automatic clear_obs();
      obs_snd_c.delete(); obs_done_c.delete(); obs_upd_c.delete();
      obs_err_c.delete(); obs_cmd.delete(); obs_upd.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] ec [4];
      logic [3:0]  eu [4];
      logic [11:0] snap [4];
      int          n;
      n_chk = 0; n_fail = 0; cyc = 0;
      ec = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
      eu = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
      adc_val[0] = 12'h300; adc_val[4] = 12'h2A0;
      adc_val[5] = 12'h800; adc_val[6] = 12'hC00;
      adc_mute = 0; inj_req = 0;
      rst = 1'b1; bus.nxt = 1'b0;
      @(posedge clk); #1;
      repeat (3) step();
      chk("rst_cmd",  bus.cmd,  16'h0000);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_upd",  bus.upd,  4'b0000);
      chk("rst_lft",  bus.lft_ld, 12'h000);
      rst = 1'b0;
      step();

      // Four conversions across all slots.
      clear_obs();
      for (int i = 0; i < 4; i++) begin pulse_nxt(); wait_idle(); end
      chk("s1_nsnd", obs_cmd.size(), 8);
      chk("s1_nupd", obs_upd.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("s1_cmd", (2*i+1 < obs_cmd.size()) ? obs_cmd[2*i+1] : 16'hxxxx, ec[i]);
         chk("s1_upd", (i < obs_upd.size()) ? obs_upd[i] : 4'hx, eu[i]);
      end
      chk("s1_lft",   bus.lft_ld,    12'h300);
      chk("s1_rght",  bus.rght_ld,   12'h2A0);
      chk("s1_steer", bus.steer_pot, 12'h800);
      chk("s1_batt",  bus.batt,      12'hC00);

      // Fifth trigger wraps to lft.
      adc_val[0] = 12'h123;
      clear_obs();
      pulse_nxt(); wait_idle();
      chk("wrap_cmd", (obs_cmd.size() > 0) ? obs_cmd[0] : 16'hxxxx, 16'h0000);
      chk("wrap_lft", bus.lft_ld, 12'h123);

      // Three extra triggers during one conversion -> one extra conversion.
      clear_obs();
      pulse_nxt();
      for (int k = 0; k < 3; k++) begin step(); pulse_nxt(); end
      wait_idle();
      chk("pend_nconv", obs_upd.size(), 2);
      chk("pend_start", (obs_snd_c.size() > 2 && obs_upd_c.size() > 0) ?
                        obs_snd_c[2] - obs_upd_c[0] : -1, 2);

      // Timeout on slot 3 (batt), then retry of the same channel.
      for (int i = 0; i < 4; i++) snap[i] = dut_res(i);
      adc_mute = 1;
      clear_obs();
      pulse_nxt();
      n = 0;
      while (obs_err_c.size() == 0 && n < 60) begin step(); n++; end
      chk("tmo_bound", n < 60, 1);
      chk("tmo_delay", (obs_err_c.size() > 0 && obs_snd_c.size() > 0) ?
                       obs_err_c[0] - obs_snd_c[0] : -1, 16);
      chk("tmo_cmd",  (obs_cmd.size() > 0) ? obs_cmd[0] : 16'hxxxx, 16'h3000);
      chk("tmo_busy", bus.busy, 1'b0);
      chk("tmo_nupd", obs_upd.size(), 0);
      for (int i = 0; i < 4; i++) chk("tmo_keep", dut_res(i), snap[i]);
      adc_mute = 0;
      wait_idle();
      clear_obs();
      pulse_nxt(); wait_idle();
      chk("retry_cmd", (obs_cmd.size() > 0) ? obs_cmd[0] : 16'hxxxx, 16'h3000);
      chk("retry_upd", (obs_upd.size() > 0) ? obs_upd[0] : 4'hx, 4'b1000);

      // Reset during GAP of a lft conversion with batt latched.
      chk("gap_pre_batt", bus.batt, 12'hC00);
      clear_obs();
      pulse_nxt();
      n = 0;
      while (!(m_act && m_ph == 2 && cyc == snd_at - 1) && n < 20) begin step(); n++; end
      chk("gap_bound", n < 20, 1);
      rst = 1'b1;
      step();
      chk("gap_batt", bus.batt, 12'h000);
      chk("gap_busy", bus.busy, 1'b0);
      rst = 1'b0;
      repeat (3) step();
      chk("gap_nupd", obs_upd.size(), 0);
      clear_obs();
      pulse_nxt(); wait_idle();
      chk("gap_restart_cmd", (obs_cmd.size() > 0) ? obs_cmd[0] : 16'hxxxx, 16'h0000);

      // Cycle positions of snd/upd relative to nxt and done.
      clear_obs();
      n = cyc;
      pulse_nxt(); wait_idle();
      chk("cyc_ndone", obs_done_c.size(), 2);
      chk("cyc_snd1", (obs_snd_c.size() > 0) ? obs_snd_c[0] : -1, n + 1);
      chk("cyc_snd2", (obs_snd_c.size() > 1 && obs_done_c.size() > 0) ?
                      obs_snd_c[1] - obs_done_c[0] : -1, 2);
      chk("cyc_upd",  (obs_upd_c.size() > 0 && obs_done_c.size() > 1) ?
                      obs_upd_c[0] - obs_done_c[1] : -1, 1);

      // Stray done while idle must be ignored.
      clear_obs();
      inj_req = 1;
      step();
      inj_req = 0;
      repeat (5) step();
      chk("idle_done_seen", obs_done_c.size(), 1);
      chk("idle_done_nsnd", obs_snd_c.size(), 0);
      chk("idle_done_nupd", obs_upd.size(), 0);

      // Random triggering with changing channel values.
      for (int t = 0; t < 600; t++) begin
         if (m_idle() && $urandom_range(0, 7) == 0)
            adc_val[chans[$urandom_range(0, 3)]] = 12'($urandom);
         bus.nxt = ($urandom_range(0, 3) == 0);
         step();
      end
      bus.nxt = 1'b0;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
